mcpu6_core: RTL and testbench

Parametrised successor of the 6-bit-instruction accumulator CPU used on the TinyTapeout user slot. It executes one instruction per rising clock edge from `inst_in`, which is driven by an external program store addressed from the multiplexed `cpu_out` bus. Datapath width and register count are generic. Register-file writes are synchronous instead of level-triggered on clock low. LDI prefixing extends to any nibble-multiple width. An optional hardware return stack adds CALL/RET.

---
 rtl/mcpu6_if.sv | 13 +
 rtl/mcpu6_core.sv | 168 ++++++++++++++++
 tb/tb_mcpu6_core.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcpu6_if.sv
// Program-store link of mcpu6_core: the instruction goes in, the clock-multiplexed pc/accu bus
// and the carry flag come out.
interface mcpu6_if #(
    parameter int DW = 8
);
    logic [5:0]    inst;
    logic [DW-1:0] cpu_out;
    logic          c_flag;

    // master: program store / host side; slave: the CPU core
    modport master (output inst, input cpu_out, input c_flag);
    modport slave  (input inst, output cpu_out, output c_flag);
endinterface

// File: rtl/mcpu6_core.sv
// Parametrised 6-bit-instruction accumulator CPU, one instruction per rising edge.
// Optional hardware return stack (CALLA/RET) enabled by defining MCPU6_STACK_EN.
module mcpu6_core #(
    parameter int DW     = 8,
    parameter int NREG   = 8,
    parameter int SDEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    mcpu6_if.slave   bus
);

    generate
        if ((DW % 4) != 0 || DW < 8 || NREG < 1 || NREG > 8 || SDEPTH < 1 || SDEPTH > 8) begin : g_bad_param
            $error("mcpu6_core: DW must be a multiple of 4 and >= 8, NREG and SDEPTH in 1..8");
        end
    endgenerate

    logic [DW-1:0] accu_reg, accu_next;
    logic [DW-1:0] pc_reg, pc_next;
    logic          c_reg, c_next;
    logic          iflag_reg, iflag_next;
    logic [DW-1:0] regs_reg [NREG];

    logic [5:0]      inst;
    logic [3:0]      imm;
    logic [2:0]      r_sel;
    logic [DW-1:0]   imm_sext;
    logic [DW-1:0]   pc_inc;
    logic [DW-1:0]   reg_rd;
    logic [NREG-1:0] reg_hit;
    logic            reg_we;

    assign inst     = bus.inst;
    assign imm      = inst[3:0];
    assign r_sel    = inst[2:0];
    assign imm_sext = {{(DW-4){imm[3]}}, imm};
    assign pc_inc   = pc_reg + DW'(1);

    // Register decode: selects at or above NREG hit nothing, so they read 0 and never write.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg_hit
            assign reg_hit[gi] = (r_sel == 3'(gi));
        end
    endgenerate

    always_comb begin
        reg_rd = '0;
        for (int i = 0; i < NREG; i++) begin
            if (reg_hit[i]) begin
                reg_rd = regs_reg[i];
            end
        end
    end

`ifdef MCPU6_STACK_EN
    localparam int SPW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;
    localparam logic [3:0] CNT_MAX = 4'(SDEPTH);

    logic [DW-1:0]  stk_reg [SDEPTH];
    logic [SPW-1:0] sp_reg;
    logic [SPW-1:0] sp_inc;
    logic [SPW-1:0] sp_dec;
    logic [3:0]     cnt_reg;
    logic           push;
    logic           pop;

    // sp is the next write slot; the ring wraps so a full stack overwrites its oldest entry.
    assign sp_inc = (sp_reg == SPW'(SDEPTH-1)) ? '0 : sp_reg + SPW'(1);
    assign sp_dec = (sp_reg == '0) ? SPW'(SDEPTH-1) : sp_reg - SPW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_reg  <= '0;
            cnt_reg <= '0;
        end else if (push) begin
            stk_reg[sp_reg] <= pc_inc;
            sp_reg          <= sp_inc;
            if (cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + 4'd1;
            end
        end else if (pop) begin
            sp_reg  <= sp_dec;
            cnt_reg <= cnt_reg - 4'd1;
        end
    end
`endif

    always_comb begin
        accu_next  = accu_reg;
        c_next     = c_reg;
        pc_next    = pc_inc;
        iflag_next = 1'b0;
        reg_we     = 1'b0;
`ifdef MCPU6_STACK_EN
        push       = 1'b0;
        pop        = 1'b0;
`endif
        case (inst[5:4])
            2'b00: begin
                if (!c_reg) begin
                    pc_next = pc_reg + imm_sext;
                end
                c_next = 1'b0;
            end
            2'b01: begin
                // Nibbles arrive most-significant first; the oldest shift out at the top.
                accu_next  = iflag_reg ? {accu_reg[DW-5:0], imm} : imm_sext;
                iflag_next = 1'b1;
            end
            default: begin
                case (inst[5:3])
                    3'b100: {c_next, accu_next} = {1'b0, accu_reg} + {1'b0, reg_rd};
                    3'b101: reg_we = 1'b1;
                    3'b110: accu_next = reg_rd;
                    default: begin
                        case (inst[2:0])
                            3'b000: accu_next = ~accu_reg;
                            3'b010: pc_next = accu_reg;
`ifdef MCPU6_STACK_EN
                            3'b011: begin
                                push    = 1'b1;
                                pc_next = accu_reg;
                            end
                            3'b100: begin
                                if (cnt_reg != 4'd0) begin
                                    pop     = 1'b1;
                                    pc_next = stk_reg[sp_dec];
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            accu_reg  <= '0;
            pc_reg    <= '0;
            c_reg     <= 1'b0;
            iflag_reg <= 1'b0;
        end else begin
            accu_reg  <= accu_next;
            pc_reg    <= pc_next;
            c_reg     <= c_next;
            iflag_reg <= iflag_next;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst) begin
                regs_reg[i] <= '0;
            end else if (reg_we && reg_hit[i]) begin
                regs_reg[i] <= accu_reg;
            end
        end
    end

    // The program store sees the pc while clk is high and the accumulator while it is low.
    assign bus.cpu_out = clk ? pc_reg : accu_reg;
    assign bus.c_flag  = c_reg;

endmodule

// File: tb/tb_mcpu6_core.sv
// Bench for mcpu6_core: two instances (DW=8/NREG=8 and DW=12/NREG=4) share one instruction
// stream and are compared against a list-based behavioural model.
module tb_mcpu6_core;

    localparam int SD = 2;

    logic clk;
    logic rst;

    mcpu6_if #(.DW(8))  bus8 ();
    mcpu6_if #(.DW(12)) bus12 ();

    mcpu6_core #(.DW(8),  .NREG(8), .SDEPTH(SD)) u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
    mcpu6_core #(.DW(12), .NREG(4), .SDEPTH(SD)) u_dut12 (.clk(clk), .rst(rst), .bus(bus12));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Model state per instance: 0 = DW8/NREG8, 1 = DW12/NREG4
    int m_accu [2];
    int m_pc   [2];
    int m_c    [2];
    int m_if   [2];
    int m_regs [2][8];
    int m_stk  [2][SD];
    int m_cnt  [2];

    logic [15:0] obs_pc   [2];
    logic [15:0] obs_accu [2];
    logic [15:0] obs_c    [2];

    task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step(int k, int w, int nreg, bit r, logic [5:0] ins);
        int mask;
        int imm;
        int s;
        int rr;
        int rv;
        int sum;
        int npc;
        bit was_ldi;
        mask    = (1 << w) - 1;
        imm     = int'(ins[3:0]);
        s       = (imm >= 8) ? imm - 16 : imm;
        rr      = int'(ins[2:0]);
        was_ldi = 1'b0;
        if (r) begin
            m_accu[k] = 0;
            m_pc[k]   = 0;
            m_c[k]    = 0;
            m_if[k]   = 0;
            m_cnt[k]  = 0;
            for (int i = 0; i < 8; i++) m_regs[k][i] = 0;
            return;
        end
        rv  = (rr < nreg) ? m_regs[k][rr] : 0;
        npc = (m_pc[k] + 1) & mask;
        if (ins[5:4] == 2'b00) begin
            if (m_c[k] == 0) npc = (m_pc[k] + s) & mask;
            m_c[k] = 0;
        end else if (ins[5:4] == 2'b01) begin
            m_accu[k] = (m_if[k] != 0) ? ((m_accu[k] * 16) + imm) & mask : s & mask;
            was_ldi   = 1'b1;
        end else if (ins[5:3] == 3'b100) begin
            sum       = m_accu[k] + rv;
            m_c[k]    = sum >> w;
            m_accu[k] = sum & mask;
        end else if (ins[5:3] == 3'b101) begin
            if (rr < nreg) m_regs[k][rr] = m_accu[k];
        end else if (ins[5:3] == 3'b110) begin
            m_accu[k] = rv;
        end else if (ins == 6'b111000) begin
            m_accu[k] = (~m_accu[k]) & mask;
        end else if (ins == 6'b111010) begin
            npc = m_accu[k];
        end
`ifdef MCPU6_STACK_EN
        else if (ins == 6'b111011) begin
            // List semantics: a full stack forgets its oldest return address.
            if (m_cnt[k] == SD) begin
                for (int i = 0; i < SD - 1; i++) m_stk[k][i] = m_stk[k][i+1];
                m_stk[k][SD-1] = npc;
            end else begin
                m_stk[k][m_cnt[k]] = npc;
                m_cnt[k]++;
            end
            npc = m_accu[k];
        end else if (ins == 6'b111100) begin
            if (m_cnt[k] > 0) begin
                m_cnt[k]--;
                npc = m_stk[k][m_cnt[k]];
            end
        end
`endif
        m_if[k] = was_ldi ? 1 : 0;
        m_pc[k] = npc;
    endtask

    task automatic run(bit r, logic [5:0] ins);
        rst        = r;
        bus8.inst  = ins;
        bus12.inst = ins;
        @(posedge clk);
        model_step(0, 8,  8, r, ins);
        model_step(1, 12, 4, r, ins);
        #2;
        obs_pc[0] = 16'(bus8.cpu_out);
        obs_pc[1] = 16'(bus12.cpu_out);
        obs_c[0]  = 16'(bus8.c_flag);
        obs_c[1]  = 16'(bus12.c_flag);
        check("pc8",  obs_pc[0], 16'(m_pc[0]));
        check("pc12", obs_pc[1], 16'(m_pc[1]));
        check("c8",   obs_c[0],  16'(m_c[0]));
        check("c12",  obs_c[1],  16'(m_c[1]));
        @(negedge clk);
        #2;
        obs_accu[0] = 16'(bus8.cpu_out);
        obs_accu[1] = 16'(bus12.cpu_out);
        check("accu8",  obs_accu[0], 16'(m_accu[0]));
        check("accu12", obs_accu[1], 16'(m_accu[1]));
        $display("txn rst=%0d inst=%b pc8=%h accu8=%h c8=%0d pc12=%h accu12=%h c12=%0d",
                 r, ins, obs_pc[0], obs_accu[0], obs_c[0][0], obs_pc[1], obs_accu[1], obs_c[1][0]);
    endtask

    localparam logic [5:0] OUT  = 6'b111001;
    localparam logic [5:0] JMPA = 6'b111010;
    localparam logic [5:0] CALL = 6'b111011;
    localparam logic [5:0] RET  = 6'b111100;

    int p;
    int p2;
    int p3;

    initial begin
        rst        = 1'b1;
        bus8.inst  = 6'b000000;
        bus12.inst = 6'b000000;

        // Reset, dirty the state, then reset again while an STA is presented
        run(1'b1, 6'b101000);
        check("rst_pc", obs_pc[0], 16'h0);
        check("rst_accu", obs_accu[0], 16'h0);
        run(1'b0, 6'b010101);
        run(1'b0, 6'b101000);
        run(1'b1, 6'b101000);
        check("rst2_pc", obs_pc[0], 16'h0);
        check("rst2_accu", obs_accu[0], 16'h0);
        check("rst2_c", obs_c[0], 16'h0);
        run(1'b0, 6'b110000);
        check("rst_r0_cleared", obs_accu[0], 16'h0);

        // LDI nibble prefixing and sign extension
        run(1'b0, OUT);
        run(1'b0, 6'b010001);
        run(1'b0, 6'b010010);
        check("ldi_12", obs_accu[0], 16'h12);
        run(1'b0, OUT);
        run(1'b0, 6'b011111);
        check("ldi_sext8", obs_accu[0], 16'hFF);
        check("ldi_sext12", obs_accu[1], 16'hFFF);

        // ADD carry, then BCC taken/not taken
        run(1'b0, OUT);
        run(1'b0, 6'b011000);
        run(1'b0, 6'b010000);
        run(1'b0, 6'b101001);
        run(1'b0, 6'b100001);
        check("add_accu", obs_accu[0], 16'h00);
        check("add_carry", obs_c[0], 16'h1);
        p = m_pc[0];
        run(1'b0, 6'b000011);
        check("bcc_c1_pc", obs_pc[0], 16'((p + 1) & 8'hFF));
        check("bcc_c1_clr", obs_c[0], 16'h0);
        p = m_pc[0];
        run(1'b0, 6'b001110);
        check("bcc_back2", obs_pc[0], 16'((p - 2) & 8'hFF));

        // Load-after-store and out-of-range registers
        run(1'b0, 6'b010101);
        run(1'b0, 6'b101011);
        run(1'b0, 6'b010000);
        run(1'b0, 6'b110011);
        check("lda_after_sta", obs_accu[0], 16'h5);
        run(1'b0, 6'b101110);
        run(1'b0, 6'b110110);
        check("lda_r6_nreg4", obs_accu[1], 16'h0);
        check("lda_r6_nreg8", obs_accu[0], 16'h5);

        // JMPA and a 12-bit three-nibble load
        run(1'b0, OUT);
        run(1'b0, 6'b010011);
        run(1'b0, 6'b011100);
        run(1'b0, JMPA);
        check("jmpa8", obs_pc[0], 16'h3C);
        check("jmpa12", obs_pc[1], 16'h03C);
        run(1'b0, OUT);
        run(1'b0, 6'b010001);
        run(1'b0, 6'b010010);
        run(1'b0, 6'b010011);
        check("ldi_123", obs_accu[1], 16'h123);

        // Three nested calls into a two-deep stack, then three returns
        run(1'b0, OUT);
        run(1'b0, 6'b010100);
        run(1'b0, 6'b010000);
        p = m_pc[0];
        run(1'b0, CALL);
`ifdef MCPU6_STACK_EN
        check("call1_pc", obs_pc[0], 16'h40);
`else
        check("call_nop_pc", obs_pc[0], 16'((p + 1) & 8'hFF));
`endif
        run(1'b0, OUT);
        run(1'b0, 6'b010101);
        run(1'b0, 6'b010000);
        p2 = m_pc[0];
        run(1'b0, CALL);
        run(1'b0, OUT);
        run(1'b0, 6'b010110);
        run(1'b0, 6'b010000);
        p3 = m_pc[0];
        run(1'b0, CALL);
`ifdef MCPU6_STACK_EN
        check("call3_pc", obs_pc[0], 16'h60);
        run(1'b0, RET);
        check("ret1_pc", obs_pc[0], 16'((p3 + 1) & 8'hFF));
        run(1'b0, RET);
        check("ret2_pc", obs_pc[0], 16'((p2 + 1) & 8'hFF));
        p = m_pc[0];
        run(1'b0, RET);
        check("ret_empty_pc", obs_pc[0], 16'((p + 1) & 8'hFF));
`else
        check("call3_nop_pc", obs_pc[0], 16'((p3 + 1) & 8'hFF));
        p = m_pc[0];
        run(1'b0, RET);
        check("ret_nop_pc", obs_pc[0], 16'((p + 1) & 8'hFF));
`endif

        // Random instruction stream with occasional resets
        for (int i = 0; i < 400; i++) begin
            run(($urandom_range(0, 39) == 0), 6'($urandom_range(0, 63)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
